// File: rtl/and_bank_bist.sv
// Parametrised bank of N-input AND gates with registered outputs and an
// exhaustive self-test sequencer (pattern generator, checker, fault hook).
module and_bank_bist #(
    parameter int CHANNELS = 2,
    parameter int INPUTS   = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [CHANNELS*INPUTS-1:0]   a_in,
    input  logic [CHANNELS-1:0]          fault_in,
    input  logic                         start_in,
    output logic [CHANNELS-1:0]          y_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         pass_out,
    output logic [INPUTS:0]              err_cnt_out,
    output logic [CHANNELS-1:0]          fail_mask_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [INPUTS-1:0]            pat_q, pat_d;
    logic [INPUTS:0]              err_q, err_d;
    logic [CHANNELS-1:0]          fail_q, fail_d;
    logic                         pass_q, pass_d;
    logic [CHANNELS-1:0]          y_q;
    logic [CHANNELS*INPUTS-1:0]   src;
    logic [CHANNELS-1:0]          gate;
    logic [CHANNELS-1:0]          mismatch;
    logic                         pat_last;

    assign pat_last = &pat_q;

    // During RUN every channel sees the same pattern; only the all-ones
    // pattern should produce a 1 from a healthy gate.
    always_comb begin
        src      = a_in;
        gate     = '0;
        if (state_q == RUN) begin
            src = {CHANNELS{pat_q}};
        end
        for (int c = 0; c < CHANNELS; c++) begin
            gate[c] = (&src[c*INPUTS +: INPUTS]) & ~fault_in[c];
        end
        mismatch = gate ^ {CHANNELS{pat_last}};
    end

    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can leave it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = RUN;
                    pat_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                fail_d = fail_q | mismatch;
                err_d  = err_q + {{INPUTS{1'b0}}, |mismatch};
                if (pat_last) begin
                    state_d = DONE;
                end else begin
                    pat_d = pat_q + 1'b1;
                end
            end
            DONE: begin
                pass_d  = (fail_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // sample their next values from the same pre-edge snapshot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            pat_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            y_q     <= gate;
        end
    end

    assign y_out         = y_q;
    assign busy_out      = (state_q == RUN);
    assign done_out      = (state_q == DONE);
    assign pass_out      = pass_q;
    assign err_cnt_out   = err_q;
    assign fail_mask_out = fail_q;

endmodule

// File: tb/tb_and_bank_bist.sv
// Bench for and_bank_bist: default (2x4) and re-parametrised (4x2) instances,
// table-driven functional vectors plus scoreboarded self-test runs.
module tb_and_bank_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [7:0]  a0;
    logic [1:0]  f0;
    logic        s0;
    logic [1:0]  y0;
    logic        busy0, done0, pass0;
    logic [4:0]  err0;
    logic [1:0]  mask0;

    logic [7:0]  a1;
    logic [3:0]  f1;
    logic        s1;
    logic [3:0]  y1;
    logic        busy1, done1, pass1;
    logic [2:0]  err1;
    logic [3:0]  mask1;

    and_bank_bist #(.CHANNELS(2), .INPUTS(4)) dut0 (
        .clk_in(clk), .rst_in(rst), .a_in(a0), .fault_in(f0), .start_in(s0),
        .y_out(y0), .busy_out(busy0), .done_out(done0), .pass_out(pass0),
        .err_cnt_out(err0), .fail_mask_out(mask0)
    );

    and_bank_bist #(.CHANNELS(4), .INPUTS(2)) dut1 (
        .clk_in(clk), .rst_in(rst), .a_in(a1), .fault_in(f1), .start_in(s1),
        .y_out(y1), .busy_out(busy1), .done_out(done1), .pass_out(pass1),
        .err_cnt_out(err1), .fail_mask_out(mask1)
    );

    typedef struct {
        logic       dut;
        logic [7:0] a;
        logic [3:0] f;
        logic [3:0] y;
    } vec_t;

    typedef struct {
        logic [31:0] err;
        logic [31:0] mask;
        logic [31:0] pass;
        logic [31:0] y_last;
    } bist_exp_t;

    int errors = 0;
    int checks = 0;
    int sel    = 0;

    logic [3:0]  y_exp_q[$];
    bist_exp_t   bist_q[$];

    logic        busy_s, done_s, pass_s;
    logic [31:0] err_s, mask_s, y_s;

    always_comb begin
        busy_s = (sel != 0) ? busy1 : busy0;
        done_s = (sel != 0) ? done1 : done0;
        pass_s = (sel != 0) ? pass1 : pass0;
        err_s  = (sel != 0) ? {29'b0, err1}  : {27'b0, err0};
        mask_s = (sel != 0) ? {28'b0, mask1} : {30'b0, mask0};
        y_s    = (sel != 0) ? {28'b0, y1}    : {30'b0, y0};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One self-test on the selected instance; mid_start >= 0 pulses start
    // again that many cycles into the run, which must be ignored.
    task automatic run_bist(input int s, input logic [3:0] f, input int len,
                            input bist_exp_t e, input int mid_start, input string tag);
        int        n;
        int        busy_cnt;
        bist_exp_t ex;
        sel = s;
        @(negedge clk);
        if (s == 0) begin f0 = f[1:0]; s0 = 1'b1; end
        else        begin f1 = f;      s1 = 1'b1; end
        bist_q.push_back(e);
        @(posedge clk); #1;
        s0 = 1'b0; s1 = 1'b0;
        check($sformatf("%s busy_after_start", tag), {31'b0, busy_s}, 32'd1);
        check($sformatf("%s pass_cleared", tag), {31'b0, pass_s}, 32'd0);
        n = 0;
        busy_cnt = 1;
        while (!done_s && n < 100) begin
            if (n == mid_start) begin
                if (s == 0) s0 = 1'b1; else s1 = 1'b1;
            end
            @(posedge clk); #1;
            s0 = 1'b0; s1 = 1'b0;
            n++;
            if (busy_s) busy_cnt++;
        end
        ex = bist_q.pop_front();
        check($sformatf("%s done_latency", tag), n, len);
        check($sformatf("%s busy_cycles", tag), busy_cnt, len);
        check($sformatf("%s err_cnt", tag), err_s, ex.err);
        check($sformatf("%s fail_mask", tag), mask_s, ex.mask);
        check($sformatf("%s y_last_pattern", tag), y_s, ex.y_last);
        @(posedge clk); #1;
        check($sformatf("%s done_cleared", tag), {31'b0, done_s}, 32'd0);
        check($sformatf("%s pass", tag), {31'b0, pass_s}, ex.pass);
    endtask

    vec_t vecs[12];

    initial begin
        int n;
        int dones;

        vecs[0]  = '{1'b0, 8'hFF, 4'h0, 4'h3};
        vecs[1]  = '{1'b0, 8'hF7, 4'h0, 4'h2};
        vecs[2]  = '{1'b0, 8'h7F, 4'h0, 4'h1};
        vecs[3]  = '{1'b0, 8'h00, 4'h0, 4'h0};
        vecs[4]  = '{1'b0, 8'hFF, 4'h1, 4'h2};
        vecs[5]  = '{1'b0, 8'hFF, 4'h2, 4'h1};
        vecs[6]  = '{1'b0, 8'hFF, 4'h3, 4'h0};
        vecs[7]  = '{1'b0, 8'h0F, 4'h0, 4'h1};
        vecs[8]  = '{1'b1, 8'hFF, 4'h0, 4'hF};
        vecs[9]  = '{1'b1, 8'b11_01_11_10, 4'h0, 4'hA};
        vecs[10] = '{1'b1, 8'hFF, 4'h8, 4'h7};
        vecs[11] = '{1'b1, 8'b01_11_10_11, 4'h0, 4'h5};

        rst = 1'b1;
        a0 = 8'hFF; f0 = '0; s0 = 1'b0;
        a1 = 8'hFF; f1 = '0; s1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset y0", {30'b0, y0}, 32'd0);
        check("reset y1", {28'b0, y1}, 32'd0);
        check("reset busy/done/pass", {29'b0, busy0, done0, pass0}, 32'd0);
        check("reset err/mask", {25'b0, err0, mask0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].dut) begin a1 = vecs[i].a; f1 = vecs[i].f; end
            else             begin a0 = vecs[i].a; f0 = vecs[i].f[1:0]; end
            y_exp_q.push_back(vecs[i].y);
            @(posedge clk); #1;
            check($sformatf("func vec%0d", i),
                  vecs[i].dut ? {28'b0, y1} : {30'b0, y0},
                  {28'b0, y_exp_q.pop_front()});
        end

        @(negedge clk);
        a0 = 8'hFF; f0 = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("func reset clears y", {30'b0, y0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_bist(0, 4'h0, 16, '{32'd0, 32'd0, 32'd1, 32'd3}, -1, "clean2x4");
        run_bist(0, 4'h1, 16, '{32'd1, 32'd1, 32'd0, 32'd2}, -1, "fault01");
        run_bist(0, 4'h3, 16, '{32'd1, 32'd3, 32'd0, 32'd0}, -1, "fault11");
        run_bist(0, 4'h0, 16, '{32'd0, 32'd0, 32'd1, 32'd3},  6, "mid_start");

        sel = 0;
        @(negedge clk);
        f0 = '0; s0 = 1'b1;
        @(posedge clk); #1;
        s0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun reset y/busy/done/pass", {27'b0, y0, busy0, done0, pass0}, 32'd0);
        check("midrun reset err/mask", {25'b0, err0, mask0}, 32'd0);
        rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done0 || busy0) dones++;
        end
        check("midrun no done after abort", dones, 0);
        run_bist(0, 4'h0, 16, '{32'd0, 32'd0, 32'd1, 32'd3}, -1, "after_abort");

        @(negedge clk);
        f0 = '0; s0 = 1'b1;
        @(posedge clk); #1;
        check("held busy run1", {31'b0, busy0}, 32'd1);
        n = 0;
        while (!done0 && n < 100) begin @(posedge clk); #1; n++; end
        check("held run1 latency", n, 16);
        @(posedge clk); #1;
        check("held run1 pass/busy", {30'b0, pass0, busy0}, 32'd2);
        @(posedge clk); #1;
        check("held retrigger pass/busy", {30'b0, pass0, busy0}, 32'd1);
        s0 = 1'b0;
        n = 0;
        while (!done0 && n < 100) begin @(posedge clk); #1; n++; end
        check("held run2 latency", n, 16);
        @(posedge clk); #1;
        check("held run2 pass", {31'b0, pass0}, 32'd1);

        run_bist(1, 4'h0, 4, '{32'd0, 32'd0, 32'd1, 32'd15}, -1, "clean4x2");
        run_bist(1, 4'h8, 4, '{32'd1, 32'd8, 32'd0, 32'd7},  -1, "fault1000");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
